// File: rtl/collision_pkg.sv
// Shared types and constants for the collision recovery drive sequencer.
package collision_pkg;

    // Encoding doubles as the state_dbg LED code.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        BRAKE   = 3'd2,
        BACKOFF = 3'd3,
        FAULT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        AB_IDLE    = 2'd0,
        AB_DRIVE   = 2'd1,
        AB_BACKOFF = 2'd2
    } after_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int unsigned SETTLE_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/collision_recovery_ctrl_timer.sv
// cycle_timer: dwell down-counter; a load of N makes done_c rise on the Nth cycle after the load edge.
module cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val - W'(1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/collision_recovery_ctrl.sv
// Drive sequencer: brake / back off / brake / resume on a collision, with bounded retries and a fault latch.
// Optional bump statistics counter enabled by defining COLLISION_BUMP_COUNTER_EN.
module collision_recovery_ctrl
    import collision_pkg::*;
#(
    parameter int unsigned BRAKE_CYCLES   = 4,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned RETRY_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               drive_req,
    input  logic               cmd_dir,
    input  logic               col_detect,
    input  logic               fault_clr,
    output logic               motor_en,
    output logic               motor_dir,
    output logic               sense_dir,
    output logic               busy,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_dbg,
    output logic [15:0]        bump_count
);

    localparam int unsigned TMR_MAX    = max_u(BRAKE_CYCLES, BACKOFF_CYCLES);
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
    localparam int unsigned SETTLE_LIM = BACKOFF_CYCLES - 1 - SETTLE_CYCLES;

    state_t             state, state_nxt;
    after_t             after_brake, after_nxt;
    logic               lat_dir, lat_nxt;
    logic               dir_nxt;
    logic               en_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               tmr_load_c;
    logic [TMR_W-1:0]   tmr_val_c;
    logic [TMR_W-1:0]   tmr_count;
    logic               tmr_done_c;
    logic               settle_mask_c;

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .count    (tmr_count),
        .done_c   (tmr_done_c)
    );

    // Detector still follows the old sense_dir during the first backoff cycles.
    assign settle_mask_c = (tmr_count > TMR_W'(SETTLE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        after_nxt  = after_brake;
        lat_nxt    = lat_dir;
        dir_nxt    = motor_dir;
        retry_nxt  = retry_cnt;
        tmr_load_c = 1'b0;
        tmr_val_c  = TMR_W'(BRAKE_CYCLES);

        case (state)
            IDLE: begin
                if (drive_req) begin
                    state_nxt = DRIVE;
                    dir_nxt   = cmd_dir;
                    lat_nxt   = cmd_dir;
                end
            end
            DRIVE: begin
                if (col_detect) begin
                    if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                        state_nxt  = BRAKE;
                        after_nxt  = AB_BACKOFF;
                        lat_nxt    = motor_dir;
                        retry_nxt  = retry_cnt + RETRY_W'(1);
                        tmr_load_c = 1'b1;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else if (!drive_req) begin
                    state_nxt  = BRAKE;
                    after_nxt  = AB_IDLE;
                    tmr_load_c = 1'b1;
                end else if (cmd_dir != motor_dir) begin
                    state_nxt  = BRAKE;
                    after_nxt  = AB_DRIVE;
                    lat_nxt    = cmd_dir;
                    tmr_load_c = 1'b1;
                end
            end
            BRAKE: begin
                if (tmr_done_c) begin
                    case (after_brake)
                        AB_BACKOFF: begin
                            state_nxt  = BACKOFF;
                            dir_nxt    = ~motor_dir;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = TMR_W'(BACKOFF_CYCLES);
                        end
                        AB_DRIVE: begin
                            state_nxt = DRIVE;
                            dir_nxt   = lat_dir;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            BACKOFF: begin
                if (col_detect && !settle_mask_c) begin
                    state_nxt = FAULT;
                end else if (tmr_done_c) begin
                    state_nxt  = BRAKE;
                    after_nxt  = drive_req ? AB_DRIVE : AB_IDLE;
                    tmr_load_c = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE) begin
            retry_nxt = '0;
        end
        en_nxt = (state_nxt == DRIVE) || (state_nxt == BACKOFF);
    end

    // Outputs registered from the next state so they match the state entered on each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            after_brake <= AB_IDLE;
            lat_dir     <= DIR_FWD;
            motor_en    <= 1'b0;
            motor_dir   <= DIR_FWD;
            sense_dir   <= DIR_FWD;
            busy        <= 1'b0;
            fault       <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            after_brake <= after_nxt;
            lat_dir     <= lat_nxt;
            motor_en    <= en_nxt;
            motor_dir   <= dir_nxt;
            sense_dir   <= dir_nxt;
            busy        <= (state_nxt != IDLE);
            fault       <= (state_nxt == FAULT);
            retry_cnt   <= retry_nxt;
        end
    end

    assign state_dbg = state;

`ifdef COLLISION_BUMP_COUNTER_EN
    logic col_hit_c;

    // Every collision that reaches DRIVE or an unmasked BACKOFF forces BRAKE or FAULT.
    assign col_hit_c = col_detect && ((state == DRIVE) || ((state == BACKOFF) && !settle_mask_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            bump_count <= 16'h0000;
        end else if (col_hit_c && (bump_count != 16'hFFFF)) begin
            bump_count <= bump_count + 16'd1;
        end
    end
`else
    assign bump_count = 16'h0000;
`endif

endmodule

// File: tb/tb_collision_recovery_ctrl.sv
// Scoreboard bench for collision_recovery_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_collision_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        drive_req;
    logic        cmd_dir;
    logic        col_detect;
    logic        fault_clr;
    logic        motor_en;
    logic        motor_dir;
    logic        sense_dir;
    logic        busy;
    logic        fault;
    logic [3:0]  retry_cnt;
    logic [2:0]  state_dbg;
    logic [15:0] bump_count;

`ifdef COLLISION_BUMP_COUNTER_EN
    localparam logic [15:0] BUMP_MASK = 16'hFFFF;
`else
    localparam logic [15:0] BUMP_MASK = 16'h0000;
`endif

    localparam int ST_IDLE = 0, ST_DRIVE = 1, ST_BRAKE = 2, ST_BACKOFF = 3, ST_FAULT = 4;

    typedef struct {
        int          cyc;
        string       nm;
        logic [27:0] v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    collision_recovery_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .drive_req  (drive_req),
        .cmd_dir    (cmd_dir),
        .col_detect (col_detect),
        .fault_clr  (fault_clr),
        .motor_en   (motor_en),
        .motor_dir  (motor_dir),
        .sense_dir  (sense_dir),
        .busy       (busy),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_dbg  (state_dbg),
        .bump_count (bump_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation d edges from now: {en, dir, sense, busy, fault, retry, state, bump}.
    task automatic expect_out(input int d, input string nm, input logic en, input logic dir,
                              input logic bsy, input logic flt, input int rc, input int st,
                              input int bump);
        exp_t e;
        logic [15:0] b;
        b = 16'(bump) & BUMP_MASK;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.v   = {en, dir, dir, bsy, flt, 4'(rc), 3'(st), b};
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.cyc != cyc ||
                {motor_en, motor_dir, sense_dir, busy, fault, retry_cnt, state_dbg, bump_count} != mon_e.v) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h want=%h", mon_e.nm, cyc,
                         {motor_en, motor_dir, sense_dir, busy, fault, retry_cnt, state_dbg, bump_count},
                         mon_e.v);
            end
        end
    end

    initial begin
        rst = 1'b1; drive_req = 1'b0; cmd_dir = 1'b0; col_detect = 1'b0; fault_clr = 1'b0;

        // 1: reset then start forward
        tick(3);
        expect_out(0, "reset", 0, 0, 0, 0, 0, ST_IDLE, 0);
        rst = 1'b0; drive_req = 1'b1; cmd_dir = 1'b0;
        expect_out(1, "start_drive", 1, 0, 1, 0, 0, ST_DRIVE, 0);
        tick(1);

        // 2: first hit, full brake/backoff/brake/resume
        expect_out(1,  "hit1_brake_first", 0, 0, 1, 0, 1, ST_BRAKE, 1);
        expect_out(4,  "hit1_brake_last",  0, 0, 1, 0, 1, ST_BRAKE, 1);
        expect_out(5,  "hit1_backoff_first", 1, 1, 1, 0, 1, ST_BACKOFF, 1);
        expect_out(12, "hit1_backoff_last",  1, 1, 1, 0, 1, ST_BACKOFF, 1);
        expect_out(13, "hit1_brake2_first",  0, 1, 1, 0, 1, ST_BRAKE, 1);
        expect_out(16, "hit1_brake2_last",   0, 1, 1, 0, 1, ST_BRAKE, 1);
        expect_out(17, "hit1_resume",        1, 0, 1, 0, 1, ST_DRIVE, 1);
        col_detect = 1'b1; tick(1); col_detect = 1'b0; tick(16);

        // 3: second hit, then third hit faults
        expect_out(1,  "hit2_brake",   0, 0, 1, 0, 2, ST_BRAKE, 2);
        expect_out(5,  "hit2_backoff", 1, 1, 1, 0, 2, ST_BACKOFF, 2);
        expect_out(13, "hit2_brake2",  0, 1, 1, 0, 2, ST_BRAKE, 2);
        expect_out(17, "hit2_resume",  1, 0, 1, 0, 2, ST_DRIVE, 2);
        col_detect = 1'b1; tick(1); col_detect = 1'b0; tick(16);
        expect_out(1, "hit3_fault",      0, 0, 1, 1, 2, ST_FAULT, 3);
        expect_out(3, "hit3_fault_hold", 0, 0, 1, 1, 2, ST_FAULT, 3);
        col_detect = 1'b1; tick(1); col_detect = 1'b0; drive_req = 1'b0; tick(2);
        fault_clr = 1'b1;
        expect_out(1, "fault_clr_idle",  0, 0, 0, 0, 0, ST_IDLE, 3);
        expect_out(2, "idle_hold",       0, 0, 0, 0, 0, ST_IDLE, 3);
        tick(1); fault_clr = 1'b0; tick(1);

        // 4: backoff settle masking, then blocked-both-ways fault
        drive_req = 1'b1; cmd_dir = 1'b0;
        expect_out(1, "s4_drive", 1, 0, 1, 0, 0, ST_DRIVE, 3);
        tick(1);
        expect_out(1, "s4_brake",          0, 0, 1, 0, 1, ST_BRAKE, 4);
        expect_out(5, "s4_backoff_c1",     1, 1, 1, 0, 1, ST_BACKOFF, 4);
        expect_out(6, "s4_mask_c1",        1, 1, 1, 0, 1, ST_BACKOFF, 4);
        expect_out(7, "s4_mask_c2",        1, 1, 1, 0, 1, ST_BACKOFF, 4);
        expect_out(8, "s4_backoff_fault",  0, 1, 1, 1, 1, ST_FAULT, 5);
        col_detect = 1'b1; tick(1); col_detect = 1'b0; tick(4);
        col_detect = 1'b1; tick(3); col_detect = 1'b0;
        drive_req = 1'b0; fault_clr = 1'b1;
        expect_out(1, "s4_clear", 0, 1, 0, 0, 0, ST_IDLE, 5);
        tick(1); fault_clr = 1'b0; tick(1);

        // 5: direction change with dead-time, then stop
        drive_req = 1'b1; cmd_dir = 1'b0;
        expect_out(1, "s5_drive_fwd", 1, 0, 1, 0, 0, ST_DRIVE, 5);
        tick(1);
        cmd_dir = 1'b1;
        expect_out(1, "s5_rev_brake_first", 0, 0, 1, 0, 0, ST_BRAKE, 5);
        expect_out(4, "s5_rev_brake_last",  0, 0, 1, 0, 0, ST_BRAKE, 5);
        expect_out(5, "s5_drive_rev",       1, 1, 1, 0, 0, ST_DRIVE, 5);
        tick(5);
        drive_req = 1'b0;
        expect_out(1, "s5_stop_brake_first", 0, 1, 1, 0, 0, ST_BRAKE, 5);
        expect_out(4, "s5_stop_brake_last",  0, 1, 1, 0, 0, ST_BRAKE, 5);
        expect_out(5, "s5_idle",             0, 1, 0, 0, 0, ST_IDLE, 5);
        tick(6);

        // 6: reset in the middle of a backoff
        drive_req = 1'b1; cmd_dir = 1'b1;
        expect_out(1, "s6_drive_rev", 1, 1, 1, 0, 0, ST_DRIVE, 5);
        tick(1);
        expect_out(1, "s6_brake",   0, 1, 1, 0, 1, ST_BRAKE, 6);
        expect_out(5, "s6_backoff", 1, 0, 1, 0, 1, ST_BACKOFF, 6);
        col_detect = 1'b1; tick(1); col_detect = 1'b0; tick(5);
        rst = 1'b1;
        expect_out(1, "s6_reset", 0, 0, 0, 0, 0, ST_IDLE, 0);
        tick(1);
        rst = 1'b0; drive_req = 1'b0;
        expect_out(1, "s6_post_reset_idle", 0, 0, 0, 0, 0, ST_IDLE, 0);
        tick(3);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_recovery_ctrl.md
Name: collision_recovery_ctrl

Overview:
Drive sequencer placed between the high-level motion command logic and the motor driver.
- Feeds the collision detector its direction select and consumes the detector's single colDetect result.
- On a hit in the direction of travel, it brakes, backs off, brakes again, and resumes the drive.
- A bounded retry count and a fault latch prevent endless bumping.

Parameters:
BRAKE_CYCLES, 4, dead-time cycles with motor disabled before any direction reversal (min 2)
BACKOFF_CYCLES, 8, cycles driven opposite to the command after a hit (min 3)
MAX_RETRIES, 2, collisions tolerated per drive session; the next hit enters FAULT
RETRY_W, 4, width of retry counter (must hold MAX_RETRIES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
drive_req  in  1  level; high = move
cmd_dir  in  1  0 = forward, 1 = reverse
col_detect  in  1  collision detector output, relative to sense_dir
fault_clr  in  1  single-cycle pulse; leaves FAULT
motor_en  out  1  motor driver enable
motor_dir  out  1  motor driver direction
sense_dir  out  1  direction select to collision detector (= motor_dir)
busy  out  1  high in any state except IDLE
fault  out  1  high in FAULT
retry_cnt  out  RETRY_W  collisions in current session
state_dbg  out  3  encoded state, for LEDs
bump_count  out  16  see Optional Feature

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). rst has priority over everything.
- Reset values: state=IDLE, motor_en=0, motor_dir=0, sense_dir=0, busy=0, fault=0, retry_cnt=0, bump_count=0.
- Output timing: all outputs are registered and reflect the state entered on the same edge.
- Timer: a single down-counter sets all dwell times. A state loaded with N lasts exactly N cycles.
- States and transitions:
  - IDLE: motor_en=0, retry_cnt cleared. drive_req=1 -> DRIVE. motor_dir is latched from cmd_dir on that edge.
  - DRIVE: motor_en=1.
    - col_detect=1 and retry_cnt<MAX_RETRIES -> BRAKE, with after_brake=BACKOFF and retry_cnt+1.
    - col_detect=1 and retry_cnt==MAX_RETRIES -> FAULT.
    - Else drive_req=0 -> BRAKE, with after_brake=IDLE.
    - Else cmd_dir!=motor_dir -> BRAKE, with after_brake=DRIVE and the new direction latched.
    - Collision has priority over drive_req drop, which has priority over a direction change.
  - BRAKE: motor_en=0 for BRAKE_CYCLES; col_detect is ignored. On expiry:
    - after_brake=BACKOFF -> BACKOFF, motor_dir inverted.
    - after_brake=DRIVE -> DRIVE, motor_dir = latched direction; back in DRIVE, the original command direction is restored.
    - after_brake=IDLE -> IDLE.
  - BACKOFF: motor_en=1 for BACKOFF_CYCLES.
    - col_detect is masked for the first SETTLE_CYCLES (package constant, 2) while the detector pipeline follows sense_dir.
    - Unmasked col_detect=1 -> FAULT immediately (blocked both ways).
    - On expiry -> BRAKE: after_brake=DRIVE if drive_req=1, else IDLE.
    - drive_req dropping mid-backoff does not shorten the manoeuvre.
  - FAULT: motor_en=0, fault=1. Only fault_clr=1 -> IDLE. fault_clr is ignored in every other state.
- Entry to FAULT always disables the motor on the same edge; no dead-time is needed because the motor is stopped.
- cmd_dir is sampled only in DRIVE and IDLE.
- retry_cnt never wraps; the FAULT transition guards it.

Optional Feature:
- Macro: COLLISION_BUMP_COUNTER_EN.
- Defined: bump_count increments by 1 on every edge entering BRAKE or FAULT because of a collision. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: no counter logic; bump_count is tied to 16'h0000. The port is present in both builds.

Decomposition:
- Package collision_pkg:
  - state enum: IDLE=0, DRIVE=1, BRAKE=2, BACKOFF=3, FAULT=4, which is also the state_dbg encoding.
  - DIR_FWD=0, DIR_REV=1.
  - SETTLE_CYCLES=2.
- One sub-module: cycle_timer (load, load value, done flag, width derived from max(BRAKE_CYCLES, BACKOFF_CYCLES)).

Test Plan:
1. rst=1 for 3 cycles, then drive_req=1, cmd_dir=0 -> DRIVE next edge, motor_en=1, motor_dir=0, busy=1.
2. In DRIVE, pulse col_detect=1 -> motor_en=0 for 4 cycles, then motor_dir=1 and motor_en=1 for 8 cycles, then 4 brake cycles, then DRIVE with motor_dir=0 and retry_cnt=1.
3. Three hits in one session -> third hit enters FAULT: fault=1, motor_en=0. fault_clr pulse -> IDLE, retry_cnt=0.
4. In BACKOFF, col_detect=1 at backoff cycle 1 -> ignored; col_detect=1 at backoff cycle 3 -> FAULT on the next edge.
5. In DRIVE, toggle cmd_dir to 1 -> 4 cycles of motor_en=0, then DRIVE with motor_dir=1 and sense_dir=1. Drop drive_req -> 4 brake cycles, then IDLE, busy=0.
6. Assert rst mid-BACKOFF -> all outputs return to reset values on the next edge. With COLLISION_BUMP_COUNTER_EN defined, bump_count=0 after reset and equals 3 after scenario 3.
